// File: rtl/posit_normalize_pipe.sv
// Three-stage posit encoder: regime build, align/shift with sticky, round and sign.
// Defining POSIT_NORM_INEXACT_EN adds the inexact flag and a saturating inexact counter.
module posit_normalize_pipe #(
   parameter int  POSIT_WIDTH = 32,
   parameter int  POSIT_ES    = 2,
   localparam int SW          = $clog2((POSIT_WIDTH - 2) << POSIT_ES) + 1,
   localparam int FW          = POSIT_WIDTH - POSIT_ES - 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   sign,
   input  logic                   NaR,
   input  logic                   zero,
   input  logic signed [SW-1:0]   scale,
   input  logic [FW-1:0]          fraction,
   input  logic                   guard,
   input  logic                   round,
   input  logic                   sticky,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [POSIT_WIDTH-1:0] posit_word
`ifdef POSIT_NORM_INEXACT_EN
   ,
   output logic                   inexact,
   output logic [15:0]            inexact_cnt
`endif
);

   localparam int N        = POSIT_WIDTH;
   localparam int ES       = POSIT_ES;
   localparam int MAXSCALE = (N - 2) << ES;
   localparam int PAD      = 1 << (SW - 1);
   localparam int WW       = N + 2 + PAD;

   logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic ready1, ready2, ready3;

   logic          s1_sign_q, s1_sign_d, s1_nar_q, s1_nar_d, s1_zero_q, s1_zero_d;
   logic          s1_sat_hi_q, s1_sat_hi_d, s1_sat_lo_q, s1_sat_lo_d;
   logic [1:0]    s1_pair_q, s1_pair_d;
   logic [SW-2:0] s1_shamt_q, s1_shamt_d;
   logic [N-1:0]  s1_body_q, s1_body_d;
   logic signed [SW-1:0] k;

   logic          s2_sign_q, s2_sign_d, s2_nar_q, s2_nar_d, s2_zero_q, s2_zero_d;
   logic          s2_sat_hi_q, s2_sat_hi_d, s2_sat_lo_q, s2_sat_lo_d;
   logic [N-2:0]  s2_kept_q, s2_kept_d;
   logic          s2_guard_q, s2_guard_d, s2_sticky_q, s2_sticky_d;
   logic [WW-1:0] s2_wide;
   logic signed [WW-1:0] s2_shifted;

   logic [N-1:0]  s3_word_q, s3_word_d;
   logic [N-1:0]  s3_sum;
   logic [N-2:0]  s3_mag;
   logic          s3_round_up, s3_ovf;
`ifdef POSIT_NORM_INEXACT_EN
   logic          s3_inexact_q, s3_inexact_d;
   logic [15:0]   inexact_cnt_q, inexact_cnt_d;
`endif

   assign ready3    = ~v3_q | out_ready;
   assign ready2    = ~v2_q | ready3;
   assign ready1    = ~v1_q | ready2;
   assign in_ready  = ready1 & ~rst;
   assign out_valid = v3_q;
   assign posit_word = s3_word_q;

   always_comb begin
      v1_d = ready1 ? in_valid : v1_q;
      v2_d = ready2 ? v1_q : v2_q;
      v3_d = ready3 ? v2_q : v3_q;
   end

   // Regime shift: a leading "10" (k>=0) or "01" (k<0) arithmetic-shifted by k or ~k grows the run.
   always_comb begin
      k           = scale >>> ES;
      s1_sign_d   = s1_sign_q;
      s1_nar_d    = s1_nar_q;
      s1_zero_d   = s1_zero_q;
      s1_sat_hi_d = s1_sat_hi_q;
      s1_sat_lo_d = s1_sat_lo_q;
      s1_pair_d   = s1_pair_q;
      s1_shamt_d  = s1_shamt_q;
      s1_body_d   = s1_body_q;
      if (in_valid && ready1) begin
         s1_sign_d   = sign;
         s1_nar_d    = NaR;
         s1_zero_d   = zero;
         s1_sat_hi_d = int'(scale) > MAXSCALE;
         s1_sat_lo_d = int'(scale) < -MAXSCALE;
         s1_pair_d   = k[SW-1] ? 2'b01 : 2'b10;
         s1_shamt_d  = k[SW-1] ? ~k[SW-2:0] : k[SW-2:0];
         s1_body_d   = N'({scale, fraction, guard, round, sticky});
      end
   end

   always_comb begin
      s2_wide     = {s1_pair_q, s1_body_q, {PAD{1'b0}}};
      s2_shifted  = $signed(s2_wide) >>> s1_shamt_q;
      s2_sign_d   = s2_sign_q;
      s2_nar_d    = s2_nar_q;
      s2_zero_d   = s2_zero_q;
      s2_sat_hi_d = s2_sat_hi_q;
      s2_sat_lo_d = s2_sat_lo_q;
      s2_kept_d   = s2_kept_q;
      s2_guard_d  = s2_guard_q;
      s2_sticky_d = s2_sticky_q;
      if (v1_q && ready2) begin
         s2_sign_d   = s1_sign_q;
         s2_nar_d    = s1_nar_q;
         s2_zero_d   = s1_zero_q;
         s2_sat_hi_d = s1_sat_hi_q;
         s2_sat_lo_d = s1_sat_lo_q;
         s2_kept_d   = s2_shifted[WW-1 -: N-1];
         s2_guard_d  = s2_shifted[WW-N];
         s2_sticky_d = |s2_shifted[WW-N-1:0];
      end
   end

   always_comb begin
      s3_round_up = s2_guard_q & (s2_sticky_q | s2_kept_q[0]);
      s3_sum      = {1'b0, s2_kept_q} + {{(N-1){1'b0}}, s3_round_up};
      s3_ovf      = s3_sum[N-1];
      if (s2_sat_hi_q || s3_ovf)
         s3_mag = '1;
      else if (s2_sat_lo_q)
         s3_mag = {{(N-2){1'b0}}, 1'b1};
      else
         s3_mag = s3_sum[N-2:0];
      s3_word_d = s3_word_q;
      if (v2_q && ready3) begin
         if (s2_nar_q)
            s3_word_d = {1'b1, {(N-1){1'b0}}};
         else if (s2_zero_q)
            s3_word_d = '0;
         else if (s2_sign_q)
            s3_word_d = N'(0) - {1'b0, s3_mag};
         else
            s3_word_d = {1'b0, s3_mag};
      end
   end

`ifdef POSIT_NORM_INEXACT_EN
   always_comb begin
      s3_inexact_d  = s3_inexact_q;
      inexact_cnt_d = inexact_cnt_q;
      if (v2_q && ready3)
         s3_inexact_d = ~s2_nar_q & ~s2_zero_q &
                        (s2_guard_q | s2_sticky_q | s2_sat_hi_q | s2_sat_lo_q | s3_ovf);
      if (v3_q && out_ready && s3_inexact_q && (inexact_cnt_q != 16'hFFFF))
         inexact_cnt_d = inexact_cnt_q + 16'd1;
   end

   assign inexact     = s3_inexact_q;
   assign inexact_cnt = inexact_cnt_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q <= 1'b0;  v2_q <= 1'b0;  v3_q <= 1'b0;
         s1_sign_q <= 1'b0;  s1_nar_q <= 1'b0;  s1_zero_q <= 1'b0;
         s1_sat_hi_q <= 1'b0;  s1_sat_lo_q <= 1'b0;
         s1_pair_q <= '0;  s1_shamt_q <= '0;  s1_body_q <= '0;
         s2_sign_q <= 1'b0;  s2_nar_q <= 1'b0;  s2_zero_q <= 1'b0;
         s2_sat_hi_q <= 1'b0;  s2_sat_lo_q <= 1'b0;
         s2_kept_q <= '0;  s2_guard_q <= 1'b0;  s2_sticky_q <= 1'b0;
         s3_word_q <= '0;
`ifdef POSIT_NORM_INEXACT_EN
         s3_inexact_q <= 1'b0;  inexact_cnt_q <= '0;
`endif
      end else begin
         v1_q <= v1_d;  v2_q <= v2_d;  v3_q <= v3_d;
         s1_sign_q <= s1_sign_d;  s1_nar_q <= s1_nar_d;  s1_zero_q <= s1_zero_d;
         s1_sat_hi_q <= s1_sat_hi_d;  s1_sat_lo_q <= s1_sat_lo_d;
         s1_pair_q <= s1_pair_d;  s1_shamt_q <= s1_shamt_d;  s1_body_q <= s1_body_d;
         s2_sign_q <= s2_sign_d;  s2_nar_q <= s2_nar_d;  s2_zero_q <= s2_zero_d;
         s2_sat_hi_q <= s2_sat_hi_d;  s2_sat_lo_q <= s2_sat_lo_d;
         s2_kept_q <= s2_kept_d;  s2_guard_q <= s2_guard_d;  s2_sticky_q <= s2_sticky_d;
         s3_word_q <= s3_word_d;
`ifdef POSIT_NORM_INEXACT_EN
         s3_inexact_q <= s3_inexact_d;  inexact_cnt_q <= inexact_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_posit_normalize_pipe.sv
// Scoreboard bench for posit_normalize_pipe at N=32, ES=2: directed encodings, latency,
// back-pressure streaming with hold-stability checks, and mid-stream reset.
module tb_posit_normalize_pipe;

   localparam int N  = 32;
   localparam int SW = 8;
   localparam int FW = 27;
   localparam int NV = 21;

   typedef struct packed {
      logic        sgn;
      logic        nar;
      logic        zer;
      logic [7:0]  scl;
      logic [26:0] frac;
      logic [2:0]  grs;
      logic [31:0] expv;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic          sign_i, nar_i, zero_i, guard_i, round_i, sticky_i;
   logic [SW-1:0] scale_i;
   logic [FW-1:0] fraction_i;
   logic [N-1:0]  posit_word;
`ifdef POSIT_NORM_INEXACT_EN
   logic          inexact;
   logic [15:0]   inexact_cnt;
`endif

   vec_t        vecs [NV];
   logic [31:0] exp_q [$];
   logic [31:0] cur_exp;
   int          checks = 0;
   int          failures = 0;
   bit          held = 1'b0;
   logic [31:0] held_word;

   posit_normalize_pipe #(.POSIT_WIDTH(32), .POSIT_ES(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .sign(sign_i), .NaR(nar_i), .zero(zero_i),
      .scale(scale_i), .fraction(fraction_i),
      .guard(guard_i), .round(round_i), .sticky(sticky_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .posit_word(posit_word)
`ifdef POSIT_NORM_INEXACT_EN
      , .inexact(inexact), .inexact_cnt(inexact_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      sign_i     = v.sgn;
      nar_i      = v.nar;
      zero_i     = v.zer;
      scale_i    = v.scl;
      fraction_i = v.frac;
      {guard_i, round_i, sticky_i} = v.grs;
      cur_exp    = v.expv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag);
      int c = 0;
      while (exp_q.size() != 0 && c < 60) begin
         tick();
         c++;
      end
      check_output(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: push on accept, pop/compare on transfer, and verify held outputs stay put.
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check_output("hold_valid", {31'd0, out_valid}, 32'd1);
            check_output("hold_word", posit_word, held_word);
         end
         held      = out_valid && !out_ready;
         held_word = posit_word;
         if (in_valid && in_ready)
            exp_q.push_back(cur_exp);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
               check_output("unexpected_out", posit_word, 32'hxxxxxxxx);
            else
               check_output("out_word", posit_word, exp_q.pop_front());
         end
      end
   end

   initial begin
      int          lat;
      int          idx;
      int          cyc;
      bit          acc;
      logic [3:0]  rdy_pat;

      vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'd0,   27'd0,        3'b000, 32'h40000000};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'd0,   27'h4000000,  3'b000, 32'h44000000};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'd0,   27'h4000000,  3'b000, 32'hBC000000};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'd0,   27'd0,        3'b100, 32'h40000000};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd0,   27'd1,        3'b100, 32'h40000002};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd0,   27'd0,        3'b101, 32'h40000001};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'd121, 27'd0,        3'b000, 32'h7FFFFFFF};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h80,  27'd0,        3'b000, 32'h00000001};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'd5,   27'h123,      3'b011, 32'h80000000};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h80,  27'h5555,     3'b111, 32'h00000000};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 8'd1,   27'd0,        3'b000, 32'h48000000};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 8'd4,   27'd0,        3'b000, 32'h60000000};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 8'hFF,  27'd0,        3'b000, 32'h38000000};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 8'd120, 27'd0,        3'b000, 32'h7FFFFFFF};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h88,  27'd0,        3'b000, 32'h00000001};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h80,  27'd0,        3'b000, 32'hFFFFFFFF};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 8'd8,   27'd3,        3'b000, 32'h70000001};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 8'd8,   27'd2,        3'b000, 32'h70000000};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 8'd8,   27'd6,        3'b000, 32'h70000002};
      vecs[19] = '{1'b1, 1'b0, 1'b0, 8'd121, 27'h7FFFFFF,  3'b111, 32'h80000001};
      vecs[20] = '{1'b0, 1'b1, 1'b1, 8'd0,   27'd0,        3'b000, 32'h80000000};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      apply_stimulus(vecs[0]);
      repeat (2) tick();
      check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_output("rst_word", posit_word, 32'd0);
      check_output("rst_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check_output("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      $display("[TB] directed encodings, back-to-back");
      tick();
      for (int i = 0; i < NV; i++) begin
         apply_stimulus(vecs[i]);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      wait_drain("directed_drain");

      $display("[TB] latency");
      apply_stimulus(vecs[1]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
      check_output("latency", 32'(lat), 32'd3);
      wait_drain("latency_drain");

      $display("[TB] stream with out_ready pattern 1,0,0,1");
      rdy_pat = 4'b1001;
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 300) begin
         out_ready = rdy_pat[cyc % 4];
         in_valid  = 1'($urandom_range(0, 1));
         apply_stimulus(vecs[(idx * 5 + 3) % NV]);
         @(negedge clk);
         acc = in_valid && in_ready;
         tick();
         if (acc) idx++;
         cyc++;
      end
      check_output("stream_sent", 32'(idx), 32'd8);
      in_valid = 1'b0;
      while (exp_q.size() != 0 && cyc < 400) begin
         out_ready = rdy_pat[cyc % 4];
         tick();
         cyc++;
      end
      out_ready = 1'b1;
      wait_drain("stream_drain");

      $display("[TB] reset mid-stream");
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(vecs[10 + i]);
         in_valid = 1'b1;
         tick();
      end
      check_output("fill_out_valid", {31'd0, out_valid}, 32'd1);
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      exp_q.delete();
      check_output("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check_output("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("midrst_word", posit_word, 32'd0);
      tick();
      check_output("midrst_next_valid", {31'd0, out_valid}, 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      check_output("release_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (6) tick();
      check_output("no_stale_valid", {31'd0, out_valid}, 32'd0);
      apply_stimulus(vecs[16]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_drain("after_rst_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
